interrupt_sequencer: RTL

- Accepts the external interrupt pin and waits for a safe point in the pipeline.
- At the safe point, injects a forced CALL into decode with the interrupt flag raised. The decoder then pushes PC and flags.
- Freezes fetch while the push drains, then commands a PC load from the interrupt vector.
- Tracks ISR residency until RTI commits. Sits between fetch and decode, alongside the hazard unit.

---
 rtl/interrupt_sequencer_pkg.sv | 29 ++
 rtl/irq_edge_capture.sv | 73 +++++++
 rtl/interrupt_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// interrupt_sequencer_pkg: shared types and constants for the interrupt sequencer.
//   - irq_state_e  : sequencer FSM state (3-bit encoding)
//   - OPCODE_W     : decode opcode width
//   - OP_CALL/RTI  : opcodes relevant to interrupt entry/exit
//   - is_safe()    : injection point qualifier

package interrupt_sequencer_pkg;

  localparam int unsigned OPCODE_W    = 5;
  localparam int unsigned DRAIN_CNT_W = 4;  // holds DRAIN_CYCLES-1 for DRAIN_CYCLES up to 15

  localparam logic [OPCODE_W-1:0] OP_CALL = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_RTI  = 5'b00011;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPending = 3'd1,
    StInject  = 3'd2,
    StDrain   = 3'd3,
    StVector  = 3'd4,
    StIsr     = 3'd5
  } irq_state_e;

  // Decode may only be replaced when nothing is stalled and no control transfer is in flight.
  function automatic logic is_safe(input logic hazard_stall, input logic flow_change_busy);
    return ~hazard_stall & ~flow_change_busy;
  endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// irq_edge_capture: turns the external interrupt pin into single-cycle requests and keeps a
// one-deep pending flag.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   irq_i      : external interrupt pin
//   pend_clr_i : clear the pending flag (request consumed by injection)
//   rq_o       : one-cycle request on each rising edge of the (synchronised) pin
//   pend_o     : a request is latched and not yet consumed
// Optional macro IRQ_SYNC_EN: pass irq_i through a two-flop synchroniser before edge detect.

module irq_edge_capture (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic pend_clr_i,
  output logic rq_o,
  output logic pend_o
);

  logic irq_s;
  logic int_q, int_d;
  logic pend_q, pend_d;

`ifdef IRQ_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  // Pin is assumed to already be synchronous to clk_i.
  assign irq_s = irq_i;
`endif

  assign rq_o = irq_s & ~int_q;

  always_comb begin
    int_d = irq_s;
    // Clear wins: a request arriving while the flag is still set is the dropped second request.
    if (pend_clr_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q | rq_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      int_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      int_q  <= int_d;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: waits for a safe decode slot, injects a forced CALL with the interrupt
// flag, freezes fetch while the push drains, commands the vector load, then tracks ISR
// residency until RTI commits.
//   i_clk, i_reset       : clock / synchronous active-high reset
//   i_interrupt          : external interrupt pin, rising edge = one request
//   i_hazard_stall       : decode stalled by the hazard unit
//   i_flow_change_busy   : branch/CALL/RET/RTI in flight between decode and memory
//   i_rti_commit         : RTI popped PC in the memory stage (pulse)
//   o_op_code_override   : CALL_OPCODE while overriding, else 0
//   o_override_valid     : decode uses o_op_code_override
//   o_interrupt          : decoder interrupt input (CALL also pushes flags)
//   o_pc_freeze          : hold PC and fetch register
//   o_vector_load        : PC <= M[interrupt vector] (one cycle)
//   o_in_isr             : injection through RTI commit
//   o_pending            : request latched, not yet injected
// Optional macro IRQ_SYNC_EN: two-flop synchroniser on i_interrupt (adds 2 cycles latency).

module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int unsigned          DRAIN_CYCLES = 3,
  parameter logic [OPCODE_W-1:0]  CALL_OPCODE  = OP_CALL
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_interrupt,
  input  logic                i_hazard_stall,
  input  logic                i_flow_change_busy,
  input  logic                i_rti_commit,
  output logic [OPCODE_W-1:0] o_op_code_override,
  output logic                o_override_valid,
  output logic                o_interrupt,
  output logic                o_pc_freeze,
  output logic                o_vector_load,
  output logic                o_in_isr,
  output logic                o_pending
);

  localparam logic [DRAIN_CNT_W-1:0] DrainLoad = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  irq_state_e             state_q, state_d;
  logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
  logic                   rq;
  logic                   pend;
  logic                   pend_clr;

  irq_edge_capture u_edge_capture (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .irq_i      (i_interrupt),
    .pend_clr_i (pend_clr),
    .rq_o       (rq),
    .pend_o     (pend)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rq || pend) state_d = StPending;
      end
      StPending: begin
        if (is_safe(i_hazard_stall, i_flow_change_busy)) begin
          state_d  = StInject;
          pend_clr = 1'b1;
        end
      end
      StInject: begin
        // A stalled decode did not take the CALL; keep presenting it.
        if (!i_hazard_stall) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StVector;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StVector: begin
        state_d = StIsr;
      end
      StIsr: begin
        // A request coinciding with the commit is captured through rq, not lost.
        if (i_rti_commit) begin
          state_d = (rq || pend) ? StPending : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs: decoded purely from the registered state.
  always_comb begin
    o_op_code_override = '0;
    o_override_valid   = 1'b0;
    o_interrupt        = 1'b0;
    o_pc_freeze        = 1'b0;
    o_vector_load      = 1'b0;
    o_in_isr           = 1'b0;
    o_pending          = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StPending: begin
        o_pending = 1'b1;
      end
      StInject: begin
        o_op_code_override = CALL_OPCODE;
        o_override_valid   = 1'b1;
        o_interrupt        = 1'b1;
        o_pc_freeze        = 1'b1;
        o_in_isr           = 1'b1;
      end
      StDrain: begin
        o_pc_freeze = 1'b1;
        o_in_isr    = 1'b1;
      end
      StVector: begin
        o_vector_load = 1'b1;
        o_in_isr      = 1'b1;
      end
      StIsr: begin
        o_in_isr = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
